// File: rtl/ame_sobel_feeder_pkg.sv
// Shared types and constants for the sobel line feeder.
package ame_sobel_feeder_pkg;

  localparam int unsigned SOBEL_LINES            = 6;
  localparam int unsigned DEFAULT_LINE_DATA_BITS = 7;

  typedef logic [SOBEL_LINES-1:0][DEFAULT_LINE_DATA_BITS-1:0] line_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

endpackage

// File: rtl/ame_sobel_feeder.sv
// Reads six consecutive lines of a block from line memory and streams them,
// with first/last markers, to the sobel block two cycles after each read.
module ame_sobel_feeder
  import ame_sobel_feeder_pkg::*;
#(
  parameter int unsigned LINE_DATA_BITS = 7,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned LINE_STRIDE    = 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_n_i,
  input  logic                                           blk_valid_i,
  output logic                                           blk_ready_o,
  input  logic [ADDR_BITS-1:0]                           blk_addr_i,
  output logic                                           mem_rd_en_o,
  output logic [ADDR_BITS-1:0]                           mem_rd_addr_o,
  input  logic [SOBEL_LINES*LINE_DATA_BITS-1:0]          mem_rd_data_i,
  output logic                                           comp_init_o,
  output logic [SOBEL_LINES-1:0][LINE_DATA_BITS-1:0]     line_data_o,
  output logic                                           line_valid_o,
  output logic                                           blk_done_o
);

  localparam int unsigned       CNT_BITS = 3;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(SOBEL_LINES - 1);

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   base_q, base_d;
  logic                   last_line;
  logic                   handshake;
  logic                   p1_valid, p1_first, p1_last;

  // Ready in IDLE, and on the last line so the next block follows without a gap.
  assign last_line     = (state_q == ST_READ) && (cnt_q == LAST_CNT);
  assign blk_ready_o   = (state_q == ST_IDLE) || last_line;
  assign handshake     = blk_valid_i && blk_ready_o;
  assign mem_rd_en_o   = (state_q == ST_READ);
  assign mem_rd_addr_o = base_q + ADDR_BITS'(32'(cnt_q) * LINE_STRIDE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_READ;
          cnt_d   = '0;
          base_d  = blk_addr_i;
        end
      end
      ST_READ: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end else if (handshake) begin
          cnt_d  = '0;
          base_d = blk_addr_i;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Flags ride one stage to meet the memory data, then everything is registered out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p1_valid     <= 1'b0;
      p1_first     <= 1'b0;
      p1_last      <= 1'b0;
      line_valid_o <= 1'b0;
      comp_init_o  <= 1'b0;
      blk_done_o   <= 1'b0;
      line_data_o  <= '0;
    end else begin
      p1_valid     <= mem_rd_en_o;
      p1_first     <= mem_rd_en_o && (cnt_q == '0);
      p1_last      <= last_line;
      line_valid_o <= p1_valid;
      comp_init_o  <= p1_first;
      blk_done_o   <= p1_last;
      if (p1_valid) begin
        line_data_o <= mem_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_ame_sobel_feeder.sv
// Bench for ame_sobel_feeder: directed and random block requests checked
// cycle by cycle against a queue-based model of pending reads and lines.
module tb_ame_sobel_feeder;

  localparam int unsigned LDB    = 7;
  localparam int unsigned AB     = 8;
  localparam int unsigned STRIDE = 1;
  localparam int unsigned DW     = 6 * LDB;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i = 1'b0;
  logic                     blk_valid_i = 1'b0;
  logic                     blk_ready_o;
  logic [AB-1:0]            blk_addr_i = '0;
  logic                     mem_rd_en_o;
  logic [AB-1:0]            mem_rd_addr_o;
  logic [DW-1:0]            mem_rd_data_i = '0;
  logic                     comp_init_o;
  logic [5:0][LDB-1:0]      line_data_o;
  logic                     line_valid_o;
  logic                     blk_done_o;

  ame_sobel_feeder #(
    .LINE_DATA_BITS (LDB),
    .ADDR_BITS      (AB),
    .LINE_STRIDE    (STRIDE)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .blk_valid_i   (blk_valid_i),
    .blk_ready_o   (blk_ready_o),
    .blk_addr_i    (blk_addr_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .comp_init_o   (comp_init_o),
    .line_data_o   (line_data_o),
    .line_valid_o  (line_valid_o),
    .blk_done_o    (blk_done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [256];

  // Line memory: data valid exactly one cycle after the read enable.
  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
  end

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [2:0]    idx;
  } rd_t;

  rd_t            rq[$];
  logic           p1_v, p1_i, p1_d;
  logic [DW-1:0]  p1_data;
  logic           cur_v, cur_i, cur_d;
  logic [DW-1:0]  cur_data;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    p1_v = 1'b0; p1_i = 1'b0; p1_d = 1'b0; p1_data = '0;
    cur_v = 1'b0; cur_i = 1'b0; cur_d = 1'b0; cur_data = '0;
  endtask

  task automatic check_all();
    check("blk_ready", 64'(blk_ready_o), 64'(rq.size() <= 1));
    check("rd_en", 64'(mem_rd_en_o), 64'(rq.size() > 0));
    if (rq.size() > 0) check("rd_addr", 64'(mem_rd_addr_o), 64'(rq[0].addr));
    check("line_valid", 64'(line_valid_o), 64'(cur_v));
    check("comp_init", 64'(comp_init_o), 64'(cur_i));
    check("blk_done", 64'(blk_done_o), 64'(cur_d));
    check("line_data", 64'(line_data_o), 64'(cur_data));
  endtask

  // One clock edge of the reference: shift the line pipe, retire a read, accept a block.
  task automatic advance(input logic v, input logic [AB-1:0] a);
    bit hs;
    hs = v && (rq.size() <= 1);
    cur_v = p1_v; cur_i = p1_i; cur_d = p1_d;
    if (p1_v) cur_data = p1_data;
    if (rq.size() > 0) begin
      p1_v    = 1'b1;
      p1_data = mem[rq[0].addr];
      p1_i    = (rq[0].idx == 3'd0);
      p1_d    = (rq[0].idx == 3'd5);
      void'(rq.pop_front());
    end else begin
      p1_v = 1'b0; p1_i = 1'b0; p1_d = 1'b0;
    end
    if (hs) begin
      for (int i = 0; i < 6; i++) begin
        rq.push_back('{addr: AB'(int'(a) + i * int'(STRIDE)), idx: 3'(i)});
      end
    end
  endtask

  task automatic step(input logic v, input logic [AB-1:0] a);
    @(negedge clk_i);
    blk_valid_i = v;
    blk_addr_i  = a;
    #1;
    check_all();
    @(posedge clk_i);
    advance(v, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // Async reset in the middle of the low clock phase, released just after a rising edge.
  task automatic pulse_reset();
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #2;
    blk_valid_i = 1'b0;
    rst_n_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'({$urandom, $urandom});
    model_reset();
    #3;
    check_all();
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;

    // Single block at 0x10.
    step(1'b1, 8'h10);
    idle(9);

    // Two blocks back to back, second request held until accepted.
    step(1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h40);
    idle(9);

    // Address wrap.
    step(1'b1, 8'hFD);
    idle(9);

    // Reset after the third read aborts the block.
    step(1'b1, 8'h20);
    idle(3);
    pulse_reset();
    idle(4);
    step(1'b1, 8'h30);
    idle(9);

    // Address changes while not ready are ignored; value at the last line wins.
    step(1'b1, 8'h50);
    step(1'b1, 8'h51);
    step(1'b1, 8'h52);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h90);
    idle(9);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) != 0, AB'($urandom));
    end
    idle(9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ame_sobel_feeder.md
AME_SOBEL_FEEDER -- requirements
Module: ame_sobel_feeder

Interface
REQ-001 The block SHALL have parameter LINE_DATA_BITS, default 7, giving the bits per pixel in one line element.
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, giving the line memory address width.
REQ-003 The block SHALL have parameter LINE_STRIDE, default 1, giving the address increment between consecutive lines of one block.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports clk_i and rst_n_i.
REQ-005 The block SHALL have port clk_i  in  1  clock, rising edge.
REQ-006 The block SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port blk_valid_i  in  1  block request valid.
REQ-008 The block SHALL have port blk_ready_o  out  1  block request accepted when high together with blk_valid_i.
REQ-009 The block SHALL have port blk_addr_i  in  ADDR_BITS  base line address of the requested block.
REQ-010 The block SHALL have port mem_rd_en_o  out  1  line memory read enable.
REQ-011 The block SHALL have port mem_rd_addr_o  out  ADDR_BITS  line memory read address.
REQ-012 The block SHALL have port mem_rd_data_i  in  6*LINE_DATA_BITS  line memory read data, valid exactly 1 cycle after mem_rd_en_o.
REQ-013 The block SHALL have port comp_init_o  out  1  first-line marker for the sobel block.
REQ-014 The block SHALL have port line_data_o  out  [5:0][LINE_DATA_BITS-1:0]  6-pixel line for the sobel block.
REQ-015 The block SHALL have port line_valid_o  out  1  line_data_o carries a valid line.
REQ-016 The block SHALL have port blk_done_o  out  1  one-cycle pulse with the 6th line of a block.

Function
REQ-017 FSM states SHALL be IDLE and READ; line counter cnt SHALL count 0..5.
REQ-018 In IDLE: blk_ready_o=1 and mem_rd_en_o=0; on a handshake, latch blk_addr_i into base, set cnt=0 and go to READ.
REQ-019 In READ: mem_rd_en_o=1 and mem_rd_addr_o=(base+cnt*LINE_STRIDE) mod 2^ADDR_BITS; cnt increments each cycle.
REQ-020 In READ with cnt<5: blk_ready_o=0.
REQ-021 In READ with cnt==5: blk_ready_o=1.
REQ-022 In READ with cnt==5 and a handshake: reload base, set cnt=0 and stay in READ, so blocks run back-to-back with no gap.
REQ-023 In READ with cnt==5 and no handshake: go to IDLE.
REQ-024 Output pipeline: read enable, first-line flag (cnt==0) and last-line flag (cnt==5) SHALL be delayed 1 cycle to align with mem_rd_data_i.
REQ-025 The aligned data and flags SHALL then be registered into line_data_o, line_valid_o, comp_init_o and blk_done_o.
REQ-026 Latency SHALL be 2 cycles from a read cycle to its line_valid_o cycle.
REQ-027 The 6 lines of a block SHALL appear on 6 consecutive cycles, with comp_init_o high on line 0 only and blk_done_o high on line 5 only.
REQ-028 line_data_o SHALL hold its last value while line_valid_o=0.
REQ-029 A handshake SHALL be accepted only where REQ-018 or REQ-021 allows; blk_valid_i at any other time SHALL be ignored until blk_ready_o is high.

Reset
REQ-030 Asserting rst_n_i SHALL immediately set the state to IDLE and cnt=0.
REQ-031 Asserting rst_n_i SHALL clear base, both pipeline stages, line_data_o, comp_init_o, line_valid_o and blk_done_o to 0.
REQ-032 Reset asserted mid-block SHALL abort the block with no further lines or done pulse.
REQ-033 The first handshake after rst_n_i deasserts SHALL be accepted on the first rising edge.

Structure
REQ-034 The shared ame package SHALL hold the line type ([5:0][LINE_DATA_BITS-1:0]), the FSM state enum and the constant SOBEL_LINES=6.
REQ-035 The block SHALL be a single module with no sub-modules; it connects directly to the line_data_i and comp_init_i ports of ame_sobel_block.

Verification
REQ-036 Single block, blk_addr_i=8'h10, memory holding value=address -> reads at 10..15 in consecutive cycles.
REQ-037 For the single block of REQ-036 -> lines 10..15 appear 2 cycles after each read, comp_init_o with line 10, blk_done_o with line 15.
REQ-038 Back-to-back requests 8'h00 then 8'h40 held valid -> 12 consecutive read cycles and 12 consecutive valid lines, comp_init_o at lines 0 and 6, blk_ready_o low for 5 cycles between accepts.
REQ-039 Wrap with blk_addr_i=8'hFD and LINE_STRIDE=1 -> read addresses FD,FE,FF,00,01,02.
REQ-040 rst_n_i pulsed low after the 3rd read of a block -> outputs 0 asynchronously, no blk_done_o, and a new request afterwards completes normally.
REQ-041 blk_valid_i held high through a block with blk_addr_i changing at cnt=2 -> that value is ignored and the value present at cnt==5 is accepted.
REQ-042 Pass criteria SHALL be a scoreboard comparing the read/output sequence against a cycle reference model, with zero mismatches.
